// File: rtl/ram_mmio_keybuf.sv
// Word RAM with two memory-mapped keyboard registers (data/pop and status) backed by a byte FIFO.
// Define BYTE_WRITE_EN to honour ram_byte_enable; otherwise every RAM write is a full word.
module ram_mmio_keybuf #(
  parameter int unsigned         ADDR_W        = 13,
  parameter int unsigned         DATA_W        = 32,
  parameter int unsigned         FIFO_DEPTH    = 8,
  parameter logic [ADDR_W-1:0]   KEY_DATA_ADDR = 13'h0310,
  parameter logic [ADDR_W-1:0]   KEY_STAT_ADDR = 13'h0314,
  parameter                      INIT_FILE     = "ram_mmio_keybuf.mif"
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ram_addr,
  input  logic                ram_write_enable,
  input  logic [DATA_W-1:0]   ram_write_data,
  input  logic [DATA_W/8-1:0] ram_byte_enable,
  output logic [DATA_W-1:0]   ram_read_data,
  input  logic [7:0]          key_wdata,
  input  logic                key_wen,
  output logic                key_full
);

  localparam int unsigned WORD_AW = ADDR_W - 2;
  localparam int unsigned DEPTH   = 1 << WORD_AW;
  localparam int unsigned NBYTES  = DATA_W / 8;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               overflow;
  logic               overflow_next;

  logic [WORD_AW-1:0] word_addr;
  logic               hit_data;
  logic               hit_stat;
  logic               ram_sel;
  logic               ram_we;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               ovf_set;
  logic               ovf_clr;
  logic [NBYTES-1:0]  wr_mask;
  logic [DATA_W-1:0]  rdata_next;

  // The initial image is bound to the RAM by the implementation flow, not by this model.
  logic unused_bits;
  assign unused_bits = ^{ram_addr[1:0], INIT_FILE};

  // ---------------------------------------------------------------------------
  // Address decode (byte offset bits are ignored for the mapped registers too)
  // ---------------------------------------------------------------------------
  assign word_addr = ram_addr[ADDR_W-1:2];
  assign hit_data  = (word_addr == KEY_DATA_ADDR[ADDR_W-1:2]);
  assign hit_stat  = (word_addr == KEY_STAT_ADDR[ADDR_W-1:2]);
  assign ram_sel   = !hit_data && !hit_stat;
  assign ram_we    = ram_sel && ram_write_enable && !reset;

`ifdef BYTE_WRITE_EN
  assign wr_mask = ram_byte_enable;
`else
  logic unused_be;
  assign unused_be = ^ram_byte_enable;
  assign wr_mask   = '1;
`endif

  // ---------------------------------------------------------------------------
  // Key FIFO control
  // ---------------------------------------------------------------------------
  assign key_full   = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  assign pop  = hit_data && !ram_write_enable && !fifo_empty;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign push    = key_wen && (!key_full || pop);
  assign ovf_set = key_wen && key_full && !pop;
  assign ovf_clr = hit_stat && ram_write_enable && ram_write_data[2];

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Set has priority over a simultaneous software clear.
  always_comb begin
    overflow_next = overflow;
    if (ovf_set) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_next;
      overflow <= overflow_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr] <= key_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM array (never reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_mask[i]) begin
          mem[word_addr][8*i +: 8] <= ram_write_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data mux; RAM path returns the pre-write word on write cycles
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_next = '0;
    if (ram_sel) begin
      rdata_next = mem[word_addr];
    end else if (!ram_write_enable) begin
      if (hit_data) begin
        if (!fifo_empty) begin
          rdata_next[7:0] = fifo_mem[rd_ptr];
        end
      end else begin
        rdata_next[2:0] = {overflow, key_full, !fifo_empty};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ram_read_data <= '0;
    end else begin
      ram_read_data <= rdata_next;
    end
  end

endmodule

// File: tb/tb_ram_mmio_keybuf.sv
// Directed self-checking bench for ram_mmio_keybuf (default 13-bit address, 32-bit data, depth 8).
module tb_ram_mmio_keybuf;

  logic        clock = 1'b0;
  logic        reset;
  logic [12:0] ram_addr;
  logic        ram_write_enable;
  logic [31:0] ram_write_data;
  logic [3:0]  ram_byte_enable;
  logic [31:0] ram_read_data;
  logic [7:0]  key_wdata;
  logic        key_wen;
  logic        key_full;

  int checks = 0;
  int errors = 0;

  ram_mmio_keybuf dut (
    .clock            (clock),
    .reset            (reset),
    .ram_addr         (ram_addr),
    .ram_write_enable (ram_write_enable),
    .ram_write_data   (ram_write_data),
    .ram_byte_enable  (ram_byte_enable),
    .ram_read_data    (ram_read_data),
    .key_wdata        (key_wdata),
    .key_wen          (key_wen),
    .key_full         (key_full)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_rd(input logic [12:0] a);
    ram_addr         = a;
    ram_write_enable = 1'b0;
    tick();
  endtask

  task automatic cpu_wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    ram_addr         = a;
    ram_write_enable = 1'b1;
    ram_write_data   = d;
    ram_byte_enable  = be;
    tick();
    ram_write_enable = 1'b0;
  endtask

  task automatic push(input logic [7:0] v);
    ram_addr         = 13'h0044;
    ram_write_enable = 1'b0;
    key_wen          = 1'b1;
    key_wdata        = v;
    tick();
    key_wen          = 1'b0;
  endtask

  logic [31:0] w39;
  logic [7:0]  drain_exp [8];

  initial begin
`ifdef BYTE_WRITE_EN
    w39 = 32'hDEADBE44;
`else
    w39 = 32'h11223344;
`endif
    drain_exp = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h5A};

    reset            = 1'b1;
    ram_addr         = '0;
    ram_write_enable = 1'b0;
    ram_write_data   = '0;
    ram_byte_enable  = '0;
    key_wdata        = '0;
    key_wen          = 1'b0;
    tick();
    tick();
    check("reset_rdata", ram_read_data, 32'h0);
    check("reset_full", {31'b0, key_full}, 32'h0);
    reset = 1'b0;

    // RAM word writes, byte mask, read-before-write
    cpu_wr(13'h0040, 32'hDEADBEEF, 4'hF);
    cpu_rd(13'h0040);
    check("ram_full_word", ram_read_data, 32'hDEADBEEF);
    cpu_wr(13'h0040, 32'h11223344, 4'b0001);
    cpu_rd(13'h0040);
    check("ram_byte_mask", ram_read_data, w39);
    cpu_wr(13'h0040, 32'hCAFEF00D, 4'hF);
    check("ram_rbw_old", ram_read_data, w39);
    cpu_rd(13'h0040);
    check("ram_rbw_new", ram_read_data, 32'hCAFEF00D);
    cpu_wr(13'h0044, 32'h12345678, 4'hF);
    cpu_rd(13'h0040);
    check("ram_other_addr", ram_read_data, 32'hCAFEF00D);
    cpu_rd(13'h0044);
    check("ram_addr44", ram_read_data, 32'h12345678);

    // Basic push/pop
    push(8'h41);
    push(8'h42);
    cpu_rd(13'h0314);
    check("stat_nonempty", ram_read_data, 32'h1);
    cpu_rd(13'h0310);
    check("pop_41", ram_read_data, 32'h41);
    cpu_rd(13'h0310);
    check("pop_42", ram_read_data, 32'h42);
    cpu_rd(13'h0310);
    check("pop_empty", ram_read_data, 32'h0);
    cpu_rd(13'h0314);
    check("stat_empty", ram_read_data, 32'h0);

    // Overfill, then clear overflow
    for (int i = 0; i < 9; i++) push(8'(8'h50 + i));
    check("full_flag", {31'b0, key_full}, 32'h1);
    cpu_rd(13'h0314);
    check("stat_ovf_full", ram_read_data, 32'h7);
    cpu_wr(13'h0314, 32'h4, 4'hF);
    cpu_rd(13'h0314);
    check("stat_after_clr", ram_read_data, 32'h3);

    // Push while full together with a pop
    ram_addr         = 13'h0310;
    ram_write_enable = 1'b0;
    key_wen          = 1'b1;
    key_wdata        = 8'h5A;
    tick();
    key_wen = 1'b0;
    check("full_pushpop_head", ram_read_data, 32'h50);
    check("full_pushpop_full", {31'b0, key_full}, 32'h1);
    cpu_rd(13'h0314);
    check("full_pushpop_stat", ram_read_data, 32'h3);

    // Holding the data address pops one entry per cycle
    ram_addr = 13'h0310;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("drain_%0d", i), ram_read_data, {24'b0, drain_exp[i]});
    end
    cpu_rd(13'h0314);
    check("stat_drained", ram_read_data, 32'h0);

    // Overflow set beats a same-cycle clear
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
    ram_addr         = 13'h0314;
    ram_write_enable = 1'b1;
    ram_write_data   = 32'h4;
    key_wen          = 1'b1;
    key_wdata        = 8'h77;
    tick();
    key_wen          = 1'b0;
    ram_write_enable = 1'b0;
    cpu_rd(13'h0314);
    check("ovf_set_wins", ram_read_data, 32'h7);
    cpu_wr(13'h0314, 32'h4, 4'hF);
    cpu_rd(13'h0314);
    check("ovf_cleared", ram_read_data, 32'h3);

    // Mid-operation reset with a push and pop pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(8'h71);
    push(8'h72);
    push(8'h73);
    cpu_wr(13'h0048, 32'hA5A5A5A5, 4'hF);
    ram_addr = 13'h0310;
    key_wen  = 1'b1;
    reset    = 1'b1;
    tick();
    key_wen = 1'b0;
    reset   = 1'b0;
    check("rst_rdata", ram_read_data, 32'h0);
    check("rst_full", {31'b0, key_full}, 32'h0);
    cpu_rd(13'h0314);
    check("rst_stat", ram_read_data, 32'h0);
    cpu_rd(13'h0048);
    check("rst_ram_kept", ram_read_data, 32'hA5A5A5A5);

    // Writes to the data register are ignored
    push(8'h33);
    cpu_wr(13'h0310, 32'hFF, 4'hF);
    cpu_rd(13'h0314);
    check("data_wr_ignored", ram_read_data, 32'h1);
    cpu_rd(13'h0310);
    check("pop_33", ram_read_data, 32'h33);
    cpu_rd(13'h0048);
    check("ram_untouched", ram_read_data, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
